// File: rtl/sfp_pkg.sv
// sfp_pkg: shared types and constants for the special function processor.
//   state_t          : FSM encoding (IDLE -> ACCUM -> DRAIN -> DONE)
//   PSUM_BW          : default psum lane width
//   SAT_MAX/SAT_MIN  : saturation limits for a PSUM_BW-wide signed lane
package sfp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PSUM_BW = 16;
  localparam logic signed [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

endpackage

// File: rtl/sfp_sat_add.sv
// sfp_sat_add: one combinational signed saturating adder lane.
//   a, b : bw-bit signed operands
//   y    : a+b clamped to [-2^(bw-1), 2^(bw-1)-1]
module sfp_sat_add #(
  parameter int bw = 16
) (
  input  logic [bw-1:0] a,
  input  logic [bw-1:0] b,
  output logic [bw-1:0] y
);

  logic [bw:0] s;

  // One guard bit: overflow iff the guard and sign bits disagree; the guard
  // bit then carries the true sign of the result.
  assign s = {a[bw-1], a} + {b[bw-1], b};

  always_comb begin
    y = s[bw-1:0];
    if (s[bw] != s[bw-1])
      y = s[bw] ? {1'b1, {(bw-1){1'b0}}} : {1'b0, {(bw-1){1'b1}}};
  end

endmodule

// File: rtl/sfp.sv
// sfp: special function processor downstream of the OFIFO.
// Drains OFIFO rows, accumulates them per column into a depth-row buffer over
// passes_q passes, then streams the accumulated rows out one per cycle.
// Optional macro SFP_RELU_EN: zero negative lanes on the output stream only.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   i_start/i_len/i_passes : job start pulse (IDLE only), rows per pass, passes
//   ofifo_valid/ofifo_rdata/ofifo_rd : show-ahead OFIFO head and pop
//   sfp_out/o_valid      : registered output row and its valid
//   o_busy/o_done        : job in progress, one-cycle pulse after last row
module sfp
  import sfp_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  localparam int addr_w = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [addr_w:0]        i_len,
  input  logic [3:0]             i_passes,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] ofifo_rdata,
  output logic                   ofifo_rd,
  output logic [psum_bw*col-1:0] sfp_out,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef logic [col-1:0][psum_bw-1:0] row_t;

  state_t          state, state_nx;
  logic [addr_w:0] len_q, row_cnt, len_cl;
  logic [3:0]      passes_q, pass_cnt, passes_cl;
  row_t            acc_mem [depth];
  row_t            in_row, rd_row, sum_row, out_row;
  logic [addr_w-1:0] addr;
  logic            last_row, last_pass;

  assign in_row    = ofifo_rdata;
  assign addr      = row_cnt[addr_w-1:0];
  assign rd_row    = acc_mem[addr];
  assign last_row  = (row_cnt == len_q - (addr_w+1)'(1));
  assign last_pass = (pass_cnt == passes_q - 4'd1);
  assign o_busy    = (state != IDLE);

  always_comb begin
    len_cl = i_len;
    if (i_len == '0 || i_len > (addr_w+1)'(depth)) len_cl = (addr_w+1)'(depth);
    passes_cl = (i_passes == 4'd0) ? 4'd1 : i_passes;
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_sat_add #(.bw(psum_bw)) u_add (
      .a (rd_row[i]),
      .b (in_row[i]),
      .y (sum_row[i])
    );
`ifdef SFP_RELU_EN
    assign out_row[i] = rd_row[i][psum_bw-1] ? '0 : rd_row[i];
`else
    assign out_row[i] = rd_row[i];
`endif
  end

  always_comb begin
    state_nx = state;
    ofifo_rd = 1'b0;
    case (state)
      IDLE:  if (i_start) state_nx = ACCUM;
      ACCUM: begin
        ofifo_rd = ofifo_valid;
        if (ofifo_valid && last_row && last_pass) state_nx = DRAIN;
      end
      DRAIN: if (last_row) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      passes_q <= '0;
      row_cnt  <= '0;
      pass_cnt <= '0;
      sfp_out  <= '0;
      o_valid  <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state   <= state_nx;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          len_q    <= len_cl;
          passes_q <= passes_cl;
          row_cnt  <= '0;
          pass_cnt <= '0;
        end
        ACCUM: if (ofifo_rd) begin
          if (last_row) begin
            row_cnt  <= '0;
            pass_cnt <= pass_cnt + 4'd1;
          end else begin
            row_cnt  <= row_cnt + (addr_w+1)'(1);
          end
        end
        DRAIN: begin
          sfp_out <= out_row;
          o_valid <= 1'b1;
          row_cnt <= last_row ? '0 : row_cnt + (addr_w+1)'(1);
        end
        DONE: o_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Buffer is never cleared: pass 0 overwrites, later passes accumulate.
  always_ff @(posedge clk) begin
    if (ofifo_rd) acc_mem[addr] <= (pass_cnt == 4'd0) ? in_row : sum_row;
  end

endmodule

// File: doc/sfp.md
Name: sfp

Overview:
- Special function processor: sits directly downstream of the OFIFO inside the corelet and drives the corelet's sfp_out bus.
- Drains OFIFO rows of col signed psums.
- Accumulates them per column into a depth-entry buffer over a programmed number of passes (tiles), then streams the accumulated rows out one per cycle.
- Optional ReLU is applied on the output stream.

Parameters:
- psum_bw, 16, width of one signed psum lane
- col, 8, lanes per row (matches PE array columns)
- depth, 16, accumulation buffer rows; addr_w = $clog2(depth)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse starting a job; sampled only in IDLE
- i_len  in  addr_w+1  rows per pass; 0 or >depth treated as depth
- i_passes  in  4  passes to accumulate; 0 treated as 1
- ofifo_valid  in  1  OFIFO has a row; ofifo_rdata is valid while high (show-ahead)
- ofifo_rdata  in  psum_bw*col  OFIFO head row, lane i at [psum_bw*(i+1)-1 : psum_bw*i]
- ofifo_rd  out  1  pop OFIFO head this cycle
- sfp_out  out  psum_bw*col  accumulated output row, same lane packing
- o_valid  out  1  sfp_out holds a valid row this cycle
- o_busy  out  1  job in progress (state != IDLE)
- o_done  out  1  one-cycle pulse after the last output row

Behaviour:
- Reset values (sync, active-high): state=IDLE; ofifo_rd=0, sfp_out=0, o_valid=0, o_busy=0, o_done=0; row/pass counters=0. Buffer contents are not cleared, because pass 0 overwrites them.
- FSM: IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - i_start=1 latches len_q (clamped i_len) and passes_q (clamped i_passes).
  - Clears row_cnt and pass_cnt, then moves to ACCUM.
- ACCUM:
  - ofifo_rd = ofifo_valid, combinational; no other gating.
  - On a pop, buf[row_cnt] <= (pass_cnt==0) ? ofifo_rdata : sat_add(buf[row_cnt], ofifo_rdata), per lane.
  - row_cnt increments and wraps to 0 at len_q-1, and pass_cnt increments on that wrap.
  - The pop that completes row len_q-1 of pass passes_q-1 moves the FSM to DRAIN.
  - ofifo_valid=0 stalls with no state change.
- DRAIN:
  - One row per cycle, no backpressure.
  - Registered: sfp_out <= f(buf[row_cnt]), o_valid <= 1, so the first row appears 1 cycle after entering DRAIN.
  - After len_q rows the FSM goes to DONE.
- DONE: o_valid=0, o_done=1 for exactly one cycle, then IDLE.
- o_valid=0 and sfp_out holds its last value outside DRAIN output cycles.
- Arithmetic: signed two's complement, psum_bw wide. sat_add clamps to +2^(psum_bw-1)-1 / -2^(psum_bw-1).
- Boundaries:
  - i_start while busy: ignored.
  - ofifo_valid in IDLE/DRAIN/DONE: ofifo_rd stays 0.
  - Reset mid-job: returns to IDLE next edge and drops the partial job; the next job's pass 0 overwrites the stale buffer.
  - len_q=1: every pop is a pass boundary.
  - passes_q=1: pure pass-through with buffering.
- Total latency per job: len_q*passes_q pop cycles, plus 1, plus len_q drain cycles, plus 1 done cycle.

Optional Feature:
- Macro: SFP_RELU_EN.
- Defined: f(x) zeroes every lane whose sign bit is 1, at drain time only; the accumulated buffer values stay signed.
- Undefined: f(x)=x, raw signed passthrough.

Decomposition:
- Package sfp_pkg: FSM state encoding (IDLE, ACCUM, DRAIN, DONE), plus SAT_MAX/SAT_MIN localparams derived from psum_bw.
- Sub-module sfp_sat_add: one combinational signed saturating adder lane, instantiated col times via generate.

Test Plan:
- Pass-through: len=4, passes=1, OFIFO rows r with every lane = r+1 (1..4), ofifo_valid held high -> 4 pops in 4 cycles; o_valid rows 1,2,3,4 on consecutive cycles; o_done pulses once.
- Accumulate: len=2, passes=3, each pass lanes = {5,-2} per row -> output row0 lanes=15, row1 lanes=-6.
- Saturation, psum_bw=16: len=1, passes=2, lanes 30000 then 10000 -> 32767; lanes -30000 then -10000 -> -32768.
- Stall and ignore:
  - ofifo_valid toggles 1,0,0,1 during ACCUM -> ofifo_rd mirrors it and counters advance only on pops.
  - i_start pulsed mid-job -> no effect.
  - i_len=0 -> depth rows.
- Reset mid-ACCUM after 3 of 8 pops -> next cycle o_busy=0, all outputs 0. A new job (len=2, passes=1, lanes 7) then outputs 7,7 with no stale contribution.
- ReLU: with SFP_RELU_EN, accumulated lanes {-3,4} -> sfp_out {0,4}; without the macro -> {-3,4}.
